// File: rtl/params.sv
// Shared operand-addressing types for the tile datapath: element datatype and
// the {datatype, shape} address-generator selector carried by the control chains.
package params;

    typedef enum logic [1:0] {
        DT_FP16 = 2'd0,
        DT_INT8 = 2'd1,
        DT_INT4 = 2'd2
    } datatype_t;

    typedef struct packed {
        datatype_t  datatype;
        logic [1:0] rc;
    } addrgen_t;

endpackage

// File: rtl/tile_issue_sequencer.sv
// Issues the cfg_k operand-read beats of one tile into the A/B control chains,
// waits for the skewed wavefront to drain, then pulses done.
//
//   state   | meaning
//   IDLE    | waiting for start; bad configs are rejected with err
//   ISSUE   | one beat per cycle unless hold; beat 0 carries cmen
//   DRAIN   | DRAIN_CYCLES wait for skew chain and PE pipeline to empty
//   DONE    | single-cycle done pulse, busy still high
module tile_issue_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int K_W          = 16,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  params::datatype_t   cfg_datatype,
    input  logic [1:0]          cfg_rc,
    input  logic [ADDR_W-1:0]   cfg_base_a,
    input  logic [ADDR_W-1:0]   cfg_base_b,
    input  logic [K_W-1:0]      cfg_k,
    input  logic                hold,
    output params::addrgen_t    addrtype,
    output logic                en,
    output logic                cmen,
    output logic [ADDR_W-1:0]   a_rdaddr,
    output logic [ADDR_W-1:0]   b_rdaddr,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    params::addrgen_t   r_addrtype;
    logic [ADDR_W-1:0]  r_base_a;
    logic [ADDR_W-1:0]  r_base_b;
    logic [K_W-1:0]     r_k;
    logic [K_W-1:0]     r_n;
    logic [DW-1:0]      r_drain;
    logic               r_en;
    logic               r_cmen;
    logic [ADDR_W-1:0]  r_a_rdaddr;
    logic [ADDR_W-1:0]  r_b_rdaddr;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_idle;
    logic               w_legal;
    logic               w_accept;
    logic               w_beat;
    logic               w_first;
    logic               w_last;
    params::addrgen_t   w_at;
    logic [ADDR_W-1:0]  w_src_a;
    logic [ADDR_W-1:0]  w_src_b;
    logic [ADDR_W-1:0]  w_next_a;
    logic [ADDR_W-1:0]  w_next_b;

    function automatic logic [ADDR_W-1:0] stride_a(input params::addrgen_t at);
        logic mid;
        mid = (at.rc == 2'b01) || (at.rc == 2'b10);
        if ((at.datatype == params::DT_FP16) || ((at.datatype == params::DT_INT8) && mid))
            return ADDR_W'(2);
        return ADDR_W'(4);
    endfunction

    function automatic logic [ADDR_W-1:0] stride_b(input params::addrgen_t at);
        logic mid;
        mid = (at.rc == 2'b01) || (at.rc == 2'b10);
        if (((at.datatype == params::DT_FP16) && mid) ||
            ((at.datatype == params::DT_INT8) && (at.rc == 2'b00)))
            return ADDR_W'(2);
        return ADDR_W'(4);
    endfunction

    // Beat 0 is registered on the accepting edge, so in IDLE the beat path
    // reads the configuration straight from the command inputs.
    always_comb begin
        w_at = r_addrtype;
        if (r_state == S_IDLE) begin
            w_at.datatype = cfg_datatype;
            w_at.rc       = cfg_rc;
        end
    end

    assign w_idle   = (r_state == S_IDLE);
    assign w_legal  = (cfg_k != '0) && (cfg_rc != 2'b11);
    assign w_accept = w_idle && start && w_legal;
    assign w_beat   = !hold && (w_accept || (r_state == S_ISSUE));
    assign w_first  = w_idle || (r_n == '0);
    assign w_last   = w_idle ? (cfg_k == K_W'(1)) : (r_n == r_k - K_W'(1));
    assign w_src_a  = w_idle ? cfg_base_a : r_base_a;
    assign w_src_b  = w_idle ? cfg_base_b : r_base_b;
    assign w_next_a = w_first ? w_src_a : r_a_rdaddr + stride_a(w_at);
    assign w_next_b = w_first ? w_src_b : r_b_rdaddr + stride_b(w_at);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addrtype <= '0;
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_k        <= '0;
            r_n        <= '0;
            r_drain    <= '0;
            r_en       <= 1'b0;
            r_cmen     <= 1'b0;
            r_a_rdaddr <= '0;
            r_b_rdaddr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_en   <= 1'b0;
            r_cmen <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_beat) begin
                r_en       <= 1'b1;
                r_cmen     <= w_first;
                r_a_rdaddr <= w_next_a;
                r_b_rdaddr <= w_next_b;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addrtype <= w_at;
                        r_base_a   <= cfg_base_a;
                        r_base_b   <= cfg_base_b;
                        r_k        <= cfg_k;
                        r_busy     <= 1'b1;
                        r_n        <= w_beat ? K_W'(1) : '0;
                        if (w_beat && w_last) begin
                            r_state <= S_DRAIN;
                            r_drain <= DW'(DRAIN_CYCLES);
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_beat) begin
                        r_n <= r_n + K_W'(1);
                        if (w_last) begin
                            r_state <= S_DRAIN;
                            r_drain <= DW'(DRAIN_CYCLES);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - DW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addrtype = r_addrtype;
    assign en       = r_en;
    assign cmen     = r_cmen;
    assign a_rdaddr = r_a_rdaddr;
    assign b_rdaddr = r_b_rdaddr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_tile_issue_sequencer.sv
// Scoreboard bench for tile_issue_sequencer: commands push expected beats,
// done and err events with their cycle numbers; a negedge monitor pops and compares.
module tb_tile_issue_sequencer;

    localparam int D = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    params::datatype_t cfg_datatype;
    logic [1:0]        cfg_rc;
    logic [31:0]       cfg_base_a;
    logic [31:0]       cfg_base_b;
    logic [15:0]       cfg_k;
    logic              hold;
    params::addrgen_t  addrtype;
    logic              en;
    logic              cmen;
    logic [31:0]       a_rdaddr;
    logic [31:0]       b_rdaddr;
    logic              busy;
    logic              done;
    logic              err;

    tile_issue_sequencer #(.ADDR_W(32), .K_W(16), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_datatype(cfg_datatype),
        .cfg_rc(cfg_rc), .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b),
        .cfg_k(cfg_k), .hold(hold), .addrtype(addrtype), .en(en), .cmen(cmen),
        .a_rdaddr(a_rdaddr), .b_rdaddr(b_rdaddr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic        cmen;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [3:0]  at;
    } done_t;

    beat_t beatq[$];
    done_t doneq[$];
    int    errq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cmen && !en) chk("cmen_without_en", cmen, 0);
            if (en) begin
                if (beatq.size() == 0) chk("unexpected_en", en, 0);
                else begin
                    beat_t b;
                    b = beatq.pop_front();
                    chk("beat_cycle", cyc, b.cyc);
                    chk("a_rdaddr", a_rdaddr, b.a);
                    chk("b_rdaddr", b_rdaddr, b.b);
                    chk("cmen", cmen, b.cmen);
                    chk("busy_in_issue", busy, 1);
                end
            end
            if (done) begin
                if (doneq.size() == 0) chk("unexpected_done", done, 0);
                else begin
                    done_t d;
                    d = doneq.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("addrtype", addrtype, d.at);
                    chk("busy_at_done", busy, 1);
                end
            end
            if (err) begin
                if (errq.size() == 0) chk("unexpected_err", err, 0);
                else chk("err_cycle", cyc, errq.pop_front());
            end
        end
    end

    // hfrom: index of the first beat delayed by hold (>= k means no hold).
    task automatic run_cmd(input params::datatype_t dt, input logic [1:0] rc,
                           input logic [31:0] ba, input logic [31:0] bb, input int k,
                           input int sa, input int sb, input int hfrom, input int hlen,
                           input bit spam, input bit push_done);
        int e;
        int hl;
        bit got;
        hl = (hfrom < k) ? hlen : 0;
        e  = cyc + 1;
        for (int n = 0; n < k; n++) begin
            beat_t b;
            b.cyc  = e + n + ((n >= hfrom) ? hl : 0);
            b.a    = ba + 32'(n * sa);
            b.b    = bb + 32'(n * sb);
            b.cmen = (n == 0);
            beatq.push_back(b);
        end
        if (push_done) begin
            done_t d;
            d.cyc = e + k + D + hl;
            d.at  = {dt, rc};
            doneq.push_back(d);
        end
        cfg_datatype = dt; cfg_rc = rc; cfg_base_a = ba; cfg_base_b = bb; cfg_k = 16'(k);
        start = 1'b1;
        if (hl > 0 && hfrom == 0) hold = 1'b1;
        @(posedge clk); #1;
        if (!spam) start = 1'b0;
        if (hl > 0) begin
            if (hfrom == 0) begin
                repeat (hl - 1) @(posedge clk);
                #1;
            end else begin
                while (cyc < e + hfrom - 1) begin @(posedge clk); #1; end
                hold = 1'b1;
                repeat (hl) @(posedge clk);
                #1;
            end
            hold = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        if (!got) chk("done_timeout", done, 1);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reject(input logic [1:0] rc, input int k);
        errq.push_back(cyc + 1);
        cfg_datatype = params::DT_INT8; cfg_rc = rc; cfg_k = 16'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reject_busy", busy, 0);
        chk("reject_err_cleared", err, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        cfg_datatype = params::DT_FP16; cfg_rc = 2'b00;
        cfg_base_a = '0; cfg_base_b = '0; cfg_k = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", en, 0);
        chk("rst_cmen", cmen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_a", a_rdaddr, 0);
        chk("rst_b", b_rdaddr, 0);
        chk("rst_addrtype", addrtype, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FP16 rc00: A stride 2, B stride 4, done 21 cycles after start
        run_cmd(params::DT_FP16, 2'b00, 32'h100, 32'h200, 4, 2, 4, 99, 0, 0, 1);
        wait_done();
        // INT4 rc10: strides 4/4, hold for 2 cycles after beat 1
        run_cmd(params::DT_INT4, 2'b10, 32'h1000, 32'h2000, 3, 4, 4, 2, 2, 0, 1);
        wait_done();
        // INT8 rc01 wraps A: FFFFFFFE -> 0; B stride 4
        run_cmd(params::DT_INT8, 2'b01, 32'hFFFF_FFFE, 32'h10, 2, 2, 4, 99, 0, 0, 1);
        wait_done();
        // FP16 rc01: strides 2/2; hold before beat 0, cmen must survive
        run_cmd(params::DT_FP16, 2'b01, 32'h300, 32'h400, 3, 2, 2, 0, 3, 0, 1);
        wait_done();
        // INT8 rc00: A 4, B 2; start held high for the whole command
        run_cmd(params::DT_INT8, 2'b00, 32'h500, 32'h600, 5, 4, 2, 99, 0, 1, 1);
        wait_done();
        // single beat goes straight to drain
        run_cmd(params::DT_INT4, 2'b00, 32'h700, 32'h800, 1, 4, 4, 99, 0, 0, 1);
        wait_done();

        reject(2'b00, 0);
        reject(2'b11, 4);

        // reset during DRAIN: no done, outputs cleared
        run_cmd(params::DT_FP16, 2'b00, 32'h40, 32'h80, 2, 2, 4, 99, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_en", en, 0);
        chk("mid_rst_cmen", cmen, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_a", a_rdaddr, 0);
        chk("mid_rst_b", b_rdaddr, 0);
        chk("mid_rst_addrtype", addrtype, 0);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", busy, 0);
        run_cmd(params::DT_INT8, 2'b10, 32'h900, 32'hA00, 3, 2, 4, 99, 0, 0, 1);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        chk("beats_left", beatq.size(), 0);
        chk("dones_left", doneq.size(), 0);
        chk("errs_left", errq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
